// File: rtl/regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_ctrl
// Description : Write-back controller owning the register file write port.
//               Arbitrates ALU results against buffered load returns, keeps a
//               per-register pending-load scoreboard and sequences halt.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_ctrl #(
    parameter int DATA_W    = 32,
    parameter int REG_W     = 5,
    parameter int LDQ_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              alu_valid,
    input  logic [REG_W-1:0]  alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              ld_issue_valid,
    input  logic [REG_W-1:0]  ld_issue_rd,
    output logic              ld_issue_ready,
    input  logic              ld_ret_valid,
    input  logic [REG_W-1:0]  ld_ret_rd,
    input  logic [DATA_W-1:0] ld_ret_data,
    output logic              ld_ret_ready,
    input  logic [REG_W-1:0]  rs_num,
    input  logic [REG_W-1:0]  rt_num,
    output logic              rs_busy,
    output logic              rt_busy,
    input  logic              halt_req,
    output logic              rd_we,
    output logic [REG_W-1:0]  rd_num,
    output logic [DATA_W-1:0] rd_data,
    output logic              halted
);

    localparam int c_NREG  = 1 << REG_W;
    localparam int c_PTR_W = $clog2(LDQ_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(LDQ_DEPTH);
    localparam logic [c_NREG-1:0]  c_ONE  = c_NREG'(1);

    localparam logic [1:0] c_ST_RUN    = 2'd0;
    localparam logic [1:0] c_ST_DRAIN  = 2'd1;
    localparam logic [1:0] c_ST_HALTED = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_NREG-1:0]  r_busy;
    logic [REG_W-1:0]   r_q_rd   [LDQ_DEPTH];
    logic [DATA_W-1:0]  r_q_data [LDQ_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_rr_ldq;
    logic               r_rd_we;
    logic [REG_W-1:0]   r_rd_num;
    logic [DATA_W-1:0]  r_rd_data;

    logic               w_live;
    logic               w_full;
    logic               w_empty;
    logic [REG_W-1:0]   w_head_rd;
    logic [DATA_W-1:0]  w_head_data;
    logic               w_ldq_elig;
    logic               w_alu_elig;
    logic               w_grant_ldq;
    logic               w_grant_alu;
    logic               w_push;
    logic               w_issue;
    logic               w_drain_done;
    logic [c_NREG-1:0]  w_set_vec;
    logic [c_NREG-1:0]  w_clr_vec;

    // Nothing is served once halted; only reset leaves that state.
    assign w_live      = (r_state != c_ST_HALTED);
    assign w_full      = (r_count == c_FULL);
    assign w_empty     = (r_count == '0);
    assign w_head_rd   = r_q_rd[r_rd_ptr];
    assign w_head_data = r_q_data[r_rd_ptr];

    // An ALU write behind a pending load to the same register waits (WAW).
    assign w_ldq_elig  = w_live && !w_empty;
    assign w_alu_elig  = w_live && alu_valid && !r_busy[alu_rd];

    // A full queue always wins; otherwise alternate when both contend.
    assign w_grant_ldq = w_ldq_elig && (w_full || !w_alu_elig || !r_rr_ldq);
    assign w_grant_alu = w_alu_elig && !w_grant_ldq;

    // Room is judged on current occupancy only, so a same-cycle pop never frees a slot.
    assign ld_ret_ready   = w_live && !w_full;
    assign w_push         = ld_ret_valid && ld_ret_ready;
    assign ld_issue_ready = (r_state == c_ST_RUN) && !r_busy[ld_issue_rd]
                            && !(w_grant_ldq && (w_head_rd == ld_issue_rd));
    assign w_issue        = ld_issue_valid && ld_issue_ready;

    assign alu_ready = w_grant_alu;
    assign rs_busy   = r_busy[rs_num];
    assign rt_busy   = r_busy[rt_num];
    assign rd_we     = r_rd_we;
    assign rd_num    = r_rd_num;
    assign rd_data   = r_rd_data;
    assign halted    = (r_state == c_ST_HALTED);

    // Clear beats set; register 0 can never be marked busy.
    assign w_set_vec = w_issue     ? (c_ONE << ld_issue_rd) : '0;
    assign w_clr_vec = w_grant_ldq ? (c_ONE << w_head_rd)   : '0;

    assign w_drain_done = w_empty && (r_busy == '0) && !alu_valid && !ld_ret_valid
                          && !w_grant_ldq && !w_grant_alu;

    // Pending-load scoreboard.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy | w_set_vec) & ~w_clr_vec & ~c_ONE;
        end
    end

    // Load-return queue storage; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_rd[r_wr_ptr]   <= ld_ret_rd;
            r_q_data[r_wr_ptr] <= ld_ret_data;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_grant_ldq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_grant_ldq) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_grant_ldq) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Remember which requester was granted last for round-robin.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_rr_ldq <= 1'b1;
        end else if (w_grant_ldq) begin
            r_rr_ldq <= 1'b1;
        end else if (w_grant_alu) begin
            r_rr_ldq <= 1'b0;
        end
    end

    // Registered write port; writes to r0 are consumed without a strobe.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_rd_we   <= 1'b0;
            r_rd_num  <= '0;
            r_rd_data <= '0;
        end else begin
            r_rd_we <= 1'b0;
            if (w_grant_ldq) begin
                r_rd_we   <= (w_head_rd != '0);
                r_rd_num  <= w_head_rd;
                r_rd_data <= w_head_data;
            end else if (w_grant_alu) begin
                r_rd_we   <= (alu_rd != '0);
                r_rd_num  <= alu_rd;
                r_rd_data <= alu_data;
            end
        end
    end

    // Halt sequencer state register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Halt sequencer next state; halt_req is ignored once draining has begun.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_RUN: begin
                if (halt_req) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (w_drain_done) begin
                    w_state_nxt = c_ST_HALTED;
                end
            end
            c_ST_HALTED: begin
                w_state_nxt = c_ST_HALTED;
            end
            default: begin
                w_state_nxt = c_ST_RUN;
            end
        endcase
    end

endmodule
`default_nettype wire
